// File: rtl/afifo_pkg.sv
// Shared types and width helpers for the async-FIFO write-side arbiter.
package afifo_pkg;

  // Arbiter phases: pick a requester, then stream its burst.
  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Width of a requester index / round-robin pointer.
  function automatic int unsigned idx_w(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // Width of the per-grant beat counter; holds the value MAXBURST itself.
  function automatic int unsigned cnt_w(input int unsigned maxburst);
    return $clog2(maxburst) + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester strictly after the pointer.
module rr_pick
  import afifo_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt_c,
  output logic [IW-1:0]   o_idx_c
);

  logic [IW-1:0] w_pos;
  logic          w_found;

  // Scan ptr+1 .. ptr+NREQ (mod NREQ); the pointer itself is checked last.
  always_comb begin
    o_gnt_c = '0;
    o_idx_c = '0;
    w_pos   = '0;
    w_found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_pos = IW'((32'(i_ptr) + k) % NREQ);
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_gnt_c[w_pos] = 1'b1;
        o_idx_c        = w_pos;
      end
    end
  end

endmodule

// File: rtl/afifo_wr_arb.sv
// Write-side burst arbiter in front of an async FIFO.
// Grants one requester at a time for up to MAXBURST beats, pushes each
// accepted beat one cycle later, and throttles on almost-full. Because both
// push and alFull are registered, the FIFO write logic needs at least three
// entries of headroom behind alFull.
module afifo_wr_arb
  import afifo_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DW       = 64,
  parameter int unsigned MAXBURST = 8
) (
  input  logic               wclk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  input  logic               full,
  input  logic               alFull,
  output logic               push,
  output logic [DW-1:0]      data_in,
  output logic [NREQ-1:0]    gnt,
  output logic               overflow
);

  localparam int unsigned IW = idx_w(NREQ);
  localparam int unsigned CW = cnt_w(MAXBURST);

  arb_state_t       r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [IW-1:0]    r_gidx;
  logic [IW-1:0]    r_rr_ptr;
  logic [CW-1:0]    r_beat_cnt;
  logic             r_push;
  logic [DW-1:0]    r_data;
  logic             r_ovf;

  logic [NREQ-1:0]  w_pick_gnt;
  logic [IW-1:0]    w_pick_idx;
  logic [NREQ-1:0]  w_ready;
  logic             w_accept;
  logic             w_beat_last;
  logic [DW-1:0]    w_beat_data;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_burst_end;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_gnt_c (w_pick_gnt),
    .o_idx_c (w_pick_idx)
  );

  // Only the granted requester sees ready, and only while the FIFO has room.
  assign w_ready     = ((r_state == BURST) && !alFull) ? r_gnt : '0;
  assign w_accept    = |(req_valid & w_ready);
  assign w_beat_last = req_last[r_gidx];
  assign w_beat_data = req_data[32'(r_gidx) * DW +: DW];
  assign w_cnt_nxt   = r_beat_cnt + CW'(1);
  assign w_burst_end = w_beat_last || (w_cnt_nxt == CW'(MAXBURST));

  assign req_ready = w_ready;
  assign gnt       = r_gnt;
  assign push      = r_push;
  assign data_in   = r_data;
  assign overflow  = r_ovf;

  // Arbitration FSM, push/data pipeline stage and sticky overflow flag.
  always_ff @(posedge wclk) begin
    if (!rst_n) begin
      r_state    <= ARB;
      r_gnt      <= '0;
      r_gidx     <= '0;
      r_rr_ptr   <= IW'(NREQ - 1);
      r_beat_cnt <= '0;
      r_push     <= 1'b0;
      r_data     <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_push <= w_accept;
      if (w_accept) begin
        r_data <= w_beat_data;
      end
      if (r_push && full) begin
        r_ovf <= 1'b1;
      end
      case (r_state)
        ARB: begin
          if (|req_valid && !alFull) begin
            r_gnt      <= w_pick_gnt;
            r_gidx     <= w_pick_idx;
            r_beat_cnt <= '0;
            r_state    <= BURST;
          end else begin
            r_gnt <= '0;
          end
        end
        BURST: begin
          // Grant is held through stalls and valid gaps until the burst ends.
          if (w_accept) begin
            r_beat_cnt <= w_cnt_nxt;
            if (w_burst_end) begin
              r_state  <= ARB;
              r_gnt    <= '0;
              r_rr_ptr <= r_gidx;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_afifo_wr_arb.sv
// Directed bench for afifo_wr_arb: main instance MAXBURST=4, second MAXBURST=1.
module tb_afifo_wr_arb;

  logic          wclk;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [255:0]  req_data;
  logic [3:0]    req_last;
  logic          full;
  logic          alFull;

  logic [3:0]    rdy0, gnt0, rdy1, gnt1;
  logic          push0, push1, ovf0, ovf1;
  logic [63:0]   din0, din1;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            rem [4];
  int            sent[4];
  logic          use1;
  logic [63:0]   exp_q[$];

  afifo_wr_arb #(.NREQ(4), .DW(64), .MAXBURST(4)) u_dut (
    .wclk(wclk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rdy0), .full(full), .alFull(alFull),
    .push(push0), .data_in(din0), .gnt(gnt0), .overflow(ovf0)
  );

  afifo_wr_arb #(.NREQ(4), .DW(64), .MAXBURST(1)) u_dut1 (
    .wclk(wclk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rdy1), .full(full), .alFull(alFull),
    .push(push1), .data_in(din1), .gnt(gnt1), .overflow(ovf1)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Requester i sends beat data i*256+n; last marks its final queued beat.
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]         = (rem[i] > 0);
      req_data[i*64 +: 64] = 64'(i * 256 + sent[i]);
      req_last[i]          = (rem[i] == 1);
    end
  endtask

  task automatic tick();
    logic [3:0] acc;
    @(negedge wclk);
    acc = req_valid & (use1 ? rdy1 : rdy0);
    @(posedge wclk);
    for (int i = 0; i < 4; i++) begin
      if (acc[i] === 1'b1) begin
        rem[i]--;
        sent[i]++;
      end
    end
    #1;
    drive();
  endtask

  task automatic clear_src();
    for (int i = 0; i < 4; i++) begin
      rem[i]  = 0;
      sent[i] = 0;
    end
  endtask

  task automatic do_reset();
    clear_src();
    drive();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Step k (0-based) expects nibble k of e_gnt/e_rdy and bit k of e_push/e_ovf,
  // then applies bit k of the alFull/full/rst_n controls for the next edge.
  task automatic run_seq(input string name, input int n, input logic sel1,
                         input logic [63:0] e_gnt, input logic [63:0] e_rdy,
                         input logic [15:0] e_push, input logic [15:0] e_ovf,
                         input logic [15:0] c_af, input logic [15:0] c_fl,
                         input logic [15:0] c_rs);
    logic [3:0]  g, r;
    logic        p, o;
    logic [63:0] d;
    for (int k = 0; k < n; k++) begin
      tick();
      g = sel1 ? gnt1 : gnt0;
      r = sel1 ? rdy1 : rdy0;
      p = sel1 ? push1 : push0;
      o = sel1 ? ovf1 : ovf0;
      d = sel1 ? din1 : din0;
      check($sformatf("%s.gnt%0d", name, k + 1), 64'(g), 64'(e_gnt[4*k +: 4]));
      check($sformatf("%s.rdy%0d", name, k + 1), 64'(r), 64'(e_rdy[4*k +: 4]));
      check($sformatf("%s.push%0d", name, k + 1), 64'(p), 64'(e_push[k]));
      check($sformatf("%s.ovf%0d", name, k + 1), 64'(o), 64'(e_ovf[k]));
      if (e_push[k]) begin
        check($sformatf("%s.data%0d", name, k + 1), d,
              (exp_q.size() > 0) ? exp_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF);
      end
      alFull = c_af[k];
      full   = c_fl[k];
      rst_n  = c_rs[k];
    end
    check($sformatf("%s.leftover", name), 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    full   = 1'b0;
    alFull = 1'b0;
    use1   = 1'b0;
    clear_src();
    drive();

    // Reset state
    tick();
    tick();
    check("rst.gnt",  64'(gnt0),  64'd0);
    check("rst.push", 64'(push0), 64'd0);
    check("rst.data", din0,       64'd0);
    check("rst.ovf",  64'(ovf0),  64'd0);
    check("rst.rdy",  64'(rdy0),  64'd0);
    rst_n = 1'b1;

    // Two 3-beat bursts: requester 0 then 2, one ARB cycle between
    rem[0] = 3; rem[2] = 3; drive();
    exp_q = '{64'h000, 64'h001, 64'h002, 64'h200, 64'h201, 64'h202};
    run_seq("two_bursts", 9, 1'b0, 64'h004440111, 64'h004440111,
            16'h00EE, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);

    // 10 beats from requester 1 split 4/4/2 by MAXBURST=4
    rem[1] = 10; drive();
    for (int i = 0; i < 10; i++) exp_q.push_back(64'(256 + i));
    run_seq("trunc", 14, 1'b0, 64'h00220222202222, 64'h00220222202222,
            16'h1BDE, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);

    // MAXBURST=1 with all requesters valid: strict per-beat round-robin
    do_reset();
    use1 = 1'b1;
    for (int i = 0; i < 4; i++) rem[i] = 100;
    drive();
    exp_q = '{64'h000, 64'h100, 64'h200, 64'h300, 64'h001};
    run_seq("rr1", 10, 1'b1, 64'h0108040201, 64'h0108040201,
            16'h02AA, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
    use1 = 1'b0;

    // alFull high for 5 cycles after beat 2 of a 4-beat burst
    do_reset();
    rem[0] = 4; drive();
    exp_q = '{64'h000, 64'h001, 64'h002, 64'h003};
    run_seq("alfull", 11, 1'b0, 64'h00111111111, 64'h00100000111,
            16'h0306, 16'h0000, 16'h007C, 16'h0000, 16'hFFFF);

    // Push lands while full=1: sticky overflow
    clear_src();
    rem[3] = 1; drive();
    exp_q = '{64'h300};
    run_seq("ovf", 4, 1'b0, 64'h0008, 64'h0008,
            16'h0002, 16'h000C, 16'h0000, 16'h0002, 16'hFFFF);

    // Reset in the middle of a burst clears everything, including overflow
    clear_src();
    rem[2] = 6; drive();
    exp_q = '{64'h200, 64'h201};
    run_seq("rst_mid", 4, 1'b0, 64'h0444, 64'h0444,
            16'h0006, 16'h0007, 16'h0000, 16'h0000, 16'hFFFB);
    check("rst_mid.data_zero", din0, 64'd0);

    // After reset requester 0 wins first even with requester 2 still pending
    for (int i = 0; i < 4; i++) sent[i] = 0;
    rem[0] = 2; drive();
    exp_q = '{64'h000, 64'h001};
    run_seq("post_rst", 4, 1'b0, 64'h4011, 64'h4011,
            16'h0006, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/afifo_wr_arb.md
AFIFO_WR_ARB -- requirements
Module: afifo_wr_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of write requesters (2..16).
REQ-002 SHALL have parameter DW, default 64: data width, equal to the FIFO write-side DW.
REQ-003 SHALL have parameter MAXBURST, default 8: maximum beats per grant (1..256).
REQ-004 SHALL have port wclk  input  1: write-domain clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  NREQ: per-requester beat valid.
REQ-007 SHALL have port req_data  input  NREQ*DW: per-requester beat data; requester i occupies bits [i*DW +: DW].
REQ-008 SHALL have port req_last  input  NREQ: per-requester end-of-burst marker, qualified by req_valid.
REQ-009 SHALL have port req_ready  output  NREQ: per-requester beat accept.
REQ-010 SHALL have port full  input  1: FIFO full from write logic.
REQ-011 SHALL have port alFull  input  1: FIFO almost-full from write logic.
REQ-012 SHALL have port push  output  1: registered FIFO push.
REQ-013 SHALL have port data_in  output  DW: registered FIFO write data.
REQ-014 SHALL have port gnt  output  NREQ: one-hot current grant, zero when idle.
REQ-015 SHALL have port overflow  output  1: sticky error flag, set when push is asserted while full=1.

Function
REQ-016 SHALL implement a two-state FSM, ARB and BURST.
REQ-017 In ARB, if any req_valid bit is 1 and alFull=0, SHALL grant the first valid requester at or after rr_ptr+1 (mod NREQ), load gnt, clear beat_cnt and go to BURST; otherwise SHALL stay in ARB with gnt=0.
REQ-018 req_ready[i] SHALL be 1 only when state=BURST, gnt[i]=1 and alFull=0; all other bits SHALL be 0.
REQ-019 A beat SHALL be accepted when req_valid[g] and req_ready[g] are both 1; the cycle after acceptance, push=1 and data_in equals the accepted req_data slice (latency 1).
REQ-020 push SHALL be 0 in every cycle that does not follow an accepted beat.
REQ-021 beat_cnt (width clog2(MAXBURST)+1) SHALL increment on each accepted beat.
REQ-022 After the accepting cycle, SHALL return to ARB and set rr_ptr to g when the accepted beat has req_last=1 or beat_cnt+1 equals MAXBURST; gnt SHALL become 0.
REQ-023 A burst truncated at MAXBURST SHALL resume as a new burst only when that requester next wins arbitration; no beats are dropped.
REQ-024 alFull asserting mid-burst SHALL stall (ready=0) without losing the grant; acceptance resumes when alFull deasserts.
REQ-025 req_valid deasserting mid-burst SHALL hold the grant indefinitely until the burst ends.
REQ-026 ARB SHALL cost exactly one cycle between bursts; the maximum sustained rate is MAXBURST beats per MAXBURST+1 cycles.
REQ-027 overflow SHALL set when push=1 and full=1 in the same cycle and hold until reset.
REQ-028 With MAXBURST=1, every beat SHALL be a complete burst, giving strict per-beat round-robin.
REQ-029 Correct operation SHALL require the write logic HEADROOM >= 3, covering the registered push plus the registered alFull.

Reset
REQ-030 While rst_n=0 at a rising edge, SHALL set state=ARB, gnt=0, push=0, data_in=0, beat_cnt=0, overflow=0, rr_ptr=NREQ-1 (requester 0 wins first).
REQ-031 Reset asserted mid-burst SHALL abandon the burst; beats already registered for push are discarded.

Structure
REQ-032 The state enum (ARB, BURST) and the clog2-derived width constants SHALL be in shared package afifo_pkg.
REQ-033 The round-robin pick SHALL be a combinational sub-module rr_pick (inputs: request vector, pointer; outputs: one-hot grant and index).

Verification
REQ-034 NREQ=4, MAXBURST=8: req 0 and 2 each valid with 3-beat bursts -> gnt=0001 for 3 beats, one ARB cycle, then gnt=0100; 6 pushes in order.
REQ-035 MAXBURST=4, req1 sends 10 beats with last on beat 10, req3 idle -> three bursts of 4, 4 and 2 beats, each separated by one ARB cycle.
REQ-036 All 4 requesters always valid, MAXBURST=1 -> grant sequence 0,1,2,3,0 and push every other cycle.
REQ-037 alFull forced high for 5 cycles mid-burst at beat 2 -> req_ready=0, push=0 for those cycles, gnt unchanged, beat 3 follows with correct data.
REQ-038 push forced while full=1 -> overflow=1 next cycle and held until rst_n=0; reset mid-burst -> all outputs zero next cycle, requester 0 granted first afterward.
